// File: rtl/thcattus_uart_tx.sv
// rtl/thcattus_uart_tx.sv - AXI-Stream to 8N1 UART transmitter, multi-byte beats
module thcattus_uart_tx #(
    parameter int DATA_WIDTH = 4,
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic                      axis_aclk,
    input  logic                      axis_areset,
    input  logic                      axis_tvalid,
    output logic                      axis_tready,
    input  logic [DATA_WIDTH*8-1:0]   axis_tdata,
    output logic                      uart_tx,
    output logic                      tx_busy
);

    localparam int CYCLE_PER_BAUD = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W   = (CYCLE_PER_BAUD > 1) ? $clog2(CYCLE_PER_BAUD) : 1;
    localparam int IDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int SHIFT_W = DATA_WIDTH * 8;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CYCLE_PER_BAUD - 1);
    localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [3:0]       BIT_LAST_DATA = 4'd8;
    localparam logic [3:0]       BIT_STOP      = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1
    } state_t;

    state_t               state_q, state_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;

    assign axis_tready = ready_q;
    assign uart_tx     = tx_q;
    assign tx_busy     = busy_q;

    // Next-state logic; outputs are computed one cycle ahead so every output is a flop.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;

        case (state_q)
            ST_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (axis_tvalid && ready_q) begin
                    // Start bit goes out on the handshake edge itself.
                    shift_d    = axis_tdata;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                    tx_d       = 1'b0;
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                    state_d    = ST_SEND;
                end
            end

            ST_SEND: begin
                ready_d = 1'b0;
                busy_d  = 1'b1;
                if (baud_cnt_q != BAUD_LAST) begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end else begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == BIT_STOP) begin
                        bit_idx_d = '0;
                        if (byte_idx_q != BYTE_LAST) begin
                            // Next frame starts back-to-back with the stop bit.
                            byte_idx_d = byte_idx_q + IDX_W'(1);
                            tx_d       = 1'b0;
                        end else begin
                            byte_idx_d = '0;
                            tx_d       = 1'b1;
                            ready_d    = 1'b1;
                            busy_d     = 1'b0;
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        if (bit_idx_q == BIT_LAST_DATA) begin
                            tx_d = 1'b1;
                        end else begin
                            // Shifting right walks byte 0 LSB first, then byte 1, ...
                            tx_d    = shift_q[0];
                            shift_d = shift_q >> 1;
                        end
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                tx_d       = 1'b1;
                ready_d    = 1'b0;
                busy_d     = 1'b0;
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                byte_idx_d = '0;
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    // Payload shift register; its contents are irrelevant until the next handshake.
    always_ff @(posedge axis_aclk) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_thcattus_uart_tx.sv
// tb/tb_thcattus_uart_tx.sv - directed self-checking bench for thcattus_uart_tx
module tb_thcattus_uart_tx;

    localparam int DW  = 4;
    localparam int CPB = 10;
    localparam int BEAT_CYCLES = DW * 10 * CPB;

    logic          clk = 1'b0;
    logic          areset;
    logic          tvalid;
    logic          tready;
    logic [DW*8-1:0] tdata;
    logic          uart_tx;
    logic          tx_busy;

    int n_tests = 0;
    int n_fail  = 0;

    thcattus_uart_tx #(
        .DATA_WIDTH (DW),
        .CLOCK_FREQ (1_000_000),
        .BAUD_RATE  (100_000)
    ) dut (
        .axis_aclk   (clk),
        .axis_areset (areset),
        .axis_tvalid (tvalid),
        .axis_tready (tready),
        .axis_tdata  (tdata),
        .uart_tx     (uart_tx),
        .tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line level c cycles after the handshake edge.
    function automatic logic exp_line(input logic [31:0] d, input int c);
        int f;
        int b;
        f = c / (10 * CPB);
        b = (c % (10 * CPB)) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[f*8 + b - 1];
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (tready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check({tag, "_ready_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic handshake(input logic [31:0] d, input string tag);
        wait_ready(tag);
        tdata  = d;
        tvalid = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
    endtask

    // Samples one whole beat starting right after the handshake edge.
    task automatic capture(input logic [31:0] d, input string tag, input bit wiggle);
        int bad;
        int rdy_low;
        int busy_hi;
        int b;
        logic [31:0] dec;
        bad = 0; rdy_low = 0; busy_hi = 0; dec = '0;
        for (int c = 0; c < BEAT_CYCLES; c++) begin
            @(negedge clk);
            if (uart_tx !== exp_line(d, c)) bad++;
            if (tready === 1'b0) rdy_low++;
            if (tx_busy === 1'b1) busy_hi++;
            b = (c % (10 * CPB)) / CPB;
            if ((c % CPB) == CPB/2 && b >= 1 && b <= 8)
                dec[(c / (10 * CPB)) * 8 + b - 1] = uart_tx;
            if (wiggle) begin
                tdata  = $urandom;
                tvalid = c[0];
            end
        end
        if (wiggle) tvalid = 1'b0;
        check({tag, "_line"},     64'(bad),     64'd0);
        check({tag, "_data"},     64'(dec),     64'(d));
        check({tag, "_tready_lo"}, 64'(rdy_low), 64'(BEAT_CYCLES));
        check({tag, "_busy_hi"},  64'(busy_hi), 64'(BEAT_CYCLES));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        logic [31:0] rnd;
        areset = 1'b1;
        tvalid = 1'b0;
        tdata  = '0;

        // Reset behaviour
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_tx",    64'(uart_tx), 64'd1);
            check("rst_ready", 64'(tready),  64'd0);
            check("rst_busy",  64'(tx_busy), 64'd0);
        end
        areset = 1'b0;
        @(negedge clk);
        check("rel_ready", 64'(tready), 64'd1);

        // Idle with tvalid low: line stays high
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (uart_tx === 1'b1 && tx_busy === 1'b0 && tready === 1'b1) hi++;
        end
        check("idle_quiet", 64'(hi), 64'd50);

        // Single beat
        handshake(32'h44332211, "single");
        capture(32'h44332211, "single", 1'b0);
        @(negedge clk);
        check("single_ready_back", 64'(tready), 64'd1);

        // Back-to-back beats with tvalid held high
        wait_ready("b2b");
        tdata  = 32'hA5A5A5A5;
        tvalid = 1'b1;
        @(posedge clk);
        #1;
        tdata = 32'h0000FFFF;
        capture(32'hA5A5A5A5, "b2b_a", 1'b0);
        @(negedge clk);
        check("b2b_gap_line",  64'(uart_tx), 64'd1);
        check("b2b_gap_ready", 64'(tready),  64'd1);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        capture(32'h0000FFFF, "b2b_b", 1'b0);
        @(negedge clk);
        check("b2b_done_ready", 64'(tready), 64'd1);

        // Input changes during SEND are ignored
        handshake(32'hC3E1_0F96, "wiggle");
        capture(32'hC3E1_0F96, "wiggle", 1'b1);
        @(negedge clk);
        check("wiggle_ready_back", 64'(tready), 64'd1);

        // Reset in the middle of byte 1
        handshake(32'hDEADBEEF, "midrst");
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (c == 149) begin
                check("midrst_pre_busy", 64'(tx_busy), 64'd1);
                areset = 1'b1;
            end
        end
        @(negedge clk);
        check("midrst_tx",    64'(uart_tx), 64'd1);
        check("midrst_busy",  64'(tx_busy), 64'd0);
        check("midrst_ready", 64'(tready),  64'd0);
        areset = 1'b0;
        handshake(32'h12345678, "after_rst");
        capture(32'h12345678, "after_rst", 1'b0);

        // Random beats decoded by the bench's own serial model
        for (int k = 0; k < 20; k++) begin
            rnd = $urandom;
            handshake(rnd, "rand");
            capture(rnd, "rand", 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/thcattus_uart_tx.md
Name: thcattus_uart_tx

Overview:
Generic UART transmitter with an AXI-Stream slave input. It is the transmit-side counterpart of the AXIS UART receiver.
- Accepts one DATA_WIDTH-byte beat per handshake.
- Serializes the beat as DATA_WIDTH consecutive 8N1 frames, byte 0 (tdata[7:0]) first and LSB first within each byte.
- Sits between an AXIS producer and the board-level uart_tx pin.

Parameters:
DATA_WIDTH, 4, bus width in bytes; must be >= 1
CLOCK_FREQ, 50_000_000, clock frequency in Hz
BAUD_RATE, 115200, baud rate; CYCLE_PER_BAUD = CLOCK_FREQ / BAUD_RATE (integer division, truncated); must be >= 2

Ports:
axis_aclk  input  1  single clock; all logic on rising edge
axis_areset  input  1  synchronous, active-high reset
axis_tvalid  input  1  AXIS beat valid
axis_tready  output  1  AXIS ready; registered
axis_tdata  input  DATA_WIDTH*8  beat payload
uart_tx  output  1  serial line, idle high; registered
tx_busy  output  1  high while a beat is being serialized; registered

Behaviour:
- Reset (axis_areset high at a clock edge):
  - Next state IDLE, uart_tx=1, axis_tready=0, tx_busy=0.
  - All counters cleared; the shift register is don't-care.
  - axis_tready rises at the first edge with reset low.
- Reset mid-frame: same as above. uart_tx returns to 1 at that edge, the partial frame is truncated, and the remaining bytes are discarded (no resume).
- States:
  - IDLE: axis_tready=1, uart_tx=1. On axis_tvalid&&axis_tready at edge T:
    - latch all of axis_tdata;
    - axis_tready<=0, tx_busy<=1, uart_tx<=0 (start bit starts at T);
    - byte_idx<=0, bit_idx<=0, baud_cnt<=0;
    - go to SEND.
  - SEND: baud_cnt counts 0..CYCLE_PER_BAUD-1. On wrap, bit_idx advances. Line value per bit_idx:
    - 0 = start bit (0);
    - 1..8 = data bits d0..d7 of byte byte_idx;
    - 9 = stop bit (1).
  - After stop bit completion:
    - If byte_idx < DATA_WIDTH-1: byte_idx increments and the next start bit begins immediately. There is no gap between frames inside a beat.
    - Else go to IDLE: uart_tx stays 1, axis_tready<=1, tx_busy<=0 at the same edge.
- Timing:
  - Every bit, including start and stop, is held exactly CYCLE_PER_BAUD cycles.
  - One beat occupies exactly DATA_WIDTH*10*CYCLE_PER_BAUD cycles, from handshake edge to tready re-assertion.
  - With tvalid held continuously, consecutive beats are separated by exactly 1 extra idle-high cycle (the IDLE handshake cycle).
- Handshake rules:
  - axis_tready is 0 throughout SEND.
  - axis_tdata and axis_tvalid changes during SEND are ignored.
  - Data is sampled only at the handshake edge.
  - The block never drops an accepted beat, except on reset.
  - axis_tvalid deasserted in IDLE means no action; the line stays high indefinitely.
- Widths:
  - baud_cnt is $clog2(CYCLE_PER_BAUD) bits wide, minimum 1.
  - bit_idx is 4 bits.
  - byte_idx is $clog2(DATA_WIDTH) bits wide, minimum 1.
  - No counter may wrap except as described above.
- Unreachable state encodings return to IDLE with uart_tx=1.

Test Plan:
(All scenarios except 6 use CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, so CYCLE_PER_BAUD=10, and DATA_WIDTH=4.)
1. Reset 3 cycles, then release.
   -> During reset: uart_tx=1, axis_tready=0, tx_busy=0.
   -> At the first edge after release: axis_tready=1.
2. Single beat 0x44332211, tvalid for one handshake.
   -> uart_tx emits 4 frames, each bit 10 cycles.
   -> First frame is 0,1,0,0,0,1,0,0,0,1 (0x11).
   -> Then 0x22, 0x33, 0x44 with no gaps.
   -> tready returns to 1 exactly 400 cycles after the handshake edge.
3. tvalid held high with beats 0xA5A5A5A5 then 0x0000FFFF.
   -> The second handshake occurs at the first IDLE cycle.
   -> Line is high for exactly 1 cycle between the two beats.
   -> Total time is 801 cycles from the first handshake to the second beat's completion.
4. Change axis_tdata every cycle and toggle tvalid during SEND.
   -> Output bits match only the value latched at the handshake.
   -> axis_tready=0 for all 400 cycles.
5. Assert reset at cycle 150 of a beat (mid byte 1).
   -> uart_tx=1 from the next edge; tx_busy=0.
   -> A new beat 0x12345678 after release transmits complete and correct.
6. Loopback into thcattus_uart_rx with default CLOCK_FREQ/BAUD_RATE and DATA_WIDTH=4 on both sides, sending 100 random beats.
   -> The receiver outputs identical tdata, in the same order, with no losses.
